// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
package regfile_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_t;

  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// rtl/regfile_init_seq.sv - post-reset sweep that loads reset values into the array
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int SP_INDEX = 2,
  parameter int SP_INIT  = 4092,
  parameter int AW       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            seq_we,
  output logic [AW-1:0]   seq_addr,
  output logic [XLEN-1:0] seq_data,
  output logic            init_done
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // rst_n gating keeps edges seen while reset is held from writing the array
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    seq_we    = 1'b0;
    if (state == ST_INIT) begin
      seq_we  = rst_n;
      idx_nxt = idx + 1'b1;
      if (idx == AW'(NREGS - 1)) state_nxt = ST_READY;
    end
  end

  assign seq_addr  = idx;
  assign seq_data  = (idx == AW'(SP_INDEX)) ? XLEN'(SP_INIT) : '0;
  assign init_done = (state == ST_READY);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with init sweep and debug port
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int SP_INDEX = 2,
  parameter int SP_INIT  = 4092,
  parameter int BYPASS   = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic                  wr_ready,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data,
  output logic                  init_done
);

  logic [XLEN-1:0] mem [NREGS];
  logic            seq_we;
  logic [AW-1:0]   seq_addr;
  logic [XLEN-1:0] seq_data;
  logic            ready;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  regfile_init_seq #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .SP_INDEX (SP_INDEX),
    .SP_INIT  (SP_INIT),
    .AW       (AW)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq_we    (seq_we),
    .seq_addr  (seq_addr),
    .seq_data  (seq_data),
    .init_done (ready)
  );

  assign init_done = ready;
  assign wr_ready  = ready;

  always_comb begin
    we    = ready && wr_en && (wr_addr != '0);
    waddr = wr_addr;
    wdata = wr_data;
    if (seq_we) begin
      we    = 1'b1;
      waddr = seq_addr;
      wdata = seq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    assign a = rd_addr[k*AW +: AW];
    assign d = (!ready || a == '0) ? '0 :
               ((BYPASS != 0) && wr_en && wr_addr == a) ? wr_data : mem[a];
    assign rd_data[k*XLEN +: XLEN] = d;
  end

  // Debug view deliberately skips the bypass so the display shows committed state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_data <= '0;
    else        dbg_data <= (!ready || dbg_addr == '0) ? '0 : mem[dbg_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [4:0]  dbg_addr;
  logic        b_wr_ready, b_init_done, n_wr_ready, n_init_done;
  logic [63:0] b_rd_data, n_rd_data;
  logic [31:0] b_dbg_data, n_dbg_data;

  logic        sm_wr_en;
  logic [3:0]  sm_wr_addr;
  logic [15:0] sm_wr_data;
  logic [15:0] sm_rd_addr;
  logic [3:0]  sm_dbg_addr;
  logic        sm_wr_ready, sm_init_done;
  logic [63:0] sm_rd_data;
  logic [15:0] sm_dbg_data;

  regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(b_wr_ready), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg_data), .init_done(b_init_done));

  regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(n_wr_ready), .rd_addr(rd_addr), .rd_data(n_rd_data),
    .dbg_addr(dbg_addr), .dbg_data(n_dbg_data), .init_done(n_init_done));

  regfile_mp #(.XLEN(16), .NREGS(16), .NREAD(4), .SP_INIT(16'h0FF0)) u_sm (
    .clk(clk), .rst_n(rst_n), .wr_en(sm_wr_en), .wr_addr(sm_wr_addr), .wr_data(sm_wr_data),
    .wr_ready(sm_wr_ready), .rd_addr(sm_rd_addr), .rd_data(sm_rd_data),
    .dbg_addr(sm_dbg_addr), .dbg_data(sm_dbg_data), .init_done(sm_init_done));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e1_nob;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] model[32];
  logic [31:0] dbg_q[$];

  // Counts rising edges after rst_n release until init_done rises on each size
  task automatic sweep(input bit inject, output int e_main, output int e_sm);
    e_main = 0;
    e_sm   = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (b_init_done && e_main == 0) e_main = e;
      if (sm_init_done && e_sm == 0) e_sm = e;
      if (e == 5) chk("init_rd_forced_zero", b_rd_data, 64'd0);
      if (inject && e == 9) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      end
      if (inject && e == 10) chk("init_wr_ready_low", {63'd0, b_wr_ready}, 64'd0);
      if (e == 10) wr_en = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int e_main, e_sm;
    vec_t v;
    logic [31:0] exp_dbg;

    vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd1,  32'd4092,     32'd0,        32'd0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'd0,        32'd0,        32'd0};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'd0,        32'd0,        32'd0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'd0,        32'd0,        32'd0};
    vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd3,  5'd7,  32'd0,        32'hA5A5A5A5, 32'd0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6]  = '{1'b1, 5'd9,  32'h55,       5'd2,  5'd4,  32'd4092,     32'd0,        32'd0};
    vecs[7]  = '{1'b1, 5'd2,  32'h1111,     5'd9,  5'd2,  32'h55,       32'h1111,     32'd4092};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd9,  32'h1111,     32'h55,       32'h55};
    vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd0,  5'd31, 32'd0,        32'hFFFFFFFF, 32'd0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[2] = 32'd4092;

    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = {5'd2, 5'd1}; dbg_addr = 5'd2;
    sm_wr_en = 0; sm_wr_addr = 0; sm_wr_data = 0; sm_rd_addr = 0; sm_dbg_addr = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_init_done", {63'd0, b_init_done}, 64'd0);
    chk("reset_wr_ready", {63'd0, b_wr_ready}, 64'd0);
    chk("reset_dbg_data", {32'd0, b_dbg_data}, 64'd0);
    chk("reset_rd_data", b_rd_data, 64'd0);
    rst_n = 1'b1;

    sweep(1'b1, e_main, e_sm);
    chk("init_edges_32", 64'(e_main), 64'd32);
    chk("init_edges_16", 64'(e_sm), 64'd16);
    chk("nob_init_done", {63'd0, n_init_done}, 64'd1);
    chk("ready_after_init", {63'd0, b_wr_ready}, 64'd1);

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (dbg_q.size() != 0) begin
        exp_dbg = dbg_q.pop_front();
        chk($sformatf("dbg_byp[%0d]", i - 1), {32'd0, b_dbg_data}, {32'd0, exp_dbg});
        chk($sformatf("dbg_nob[%0d]", i - 1), {32'd0, n_dbg_data}, {32'd0, exp_dbg});
      end
      v = vecs[i];
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      rd_addr = {v.ra1, v.ra0}; dbg_addr = v.ra1;
      dbg_q.push_back(v.ra1 == 5'd0 ? 32'd0 : model[v.ra1]);
      if (v.we && v.wa != 5'd0) model[v.wa] = v.wd;
      @(negedge clk);
      chk($sformatf("vec[%0d]_byp", i), b_rd_data, {v.e1, v.e0});
      chk($sformatf("vec[%0d]_nob", i), n_rd_data, {v.e1_nob, v.e0});
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    exp_dbg = dbg_q.pop_front();
    chk("dbg_byp_last", {32'd0, b_dbg_data}, {32'd0, exp_dbg});

    // Small instance: overwrite some registers, then read four distinct ones at once
    sm_wr_en = 1'b1; sm_wr_addr = 4'd3; sm_wr_data = 16'h1234;
    @(posedge clk); #1;
    sm_wr_addr = 4'd5; sm_wr_data = 16'hBEEF;
    @(posedge clk); #1;
    sm_wr_addr = 4'd15; sm_wr_data = 16'h7FFF;
    @(posedge clk); #1;
    sm_wr_en = 1'b0; sm_rd_addr = {4'd15, 4'd5, 4'd3, 4'd2}; sm_dbg_addr = 4'd15;
    @(negedge clk);
    chk("sm_four_reads", sm_rd_data, {16'h7FFF, 16'hBEEF, 16'h1234, 16'h0FF0});
    @(posedge clk); #1;
    chk("sm_dbg", {48'd0, sm_dbg_data}, {48'd0, 16'h7FFF});

    rd_addr = {5'd2, 5'd9}; dbg_addr = 5'd9;
    @(posedge clk); #1;
    chk("pre_rst_dbg", {32'd0, b_dbg_data}, 64'h55);
    chk("pre_rst_rd", b_rd_data, {32'h1111, 32'h55});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_init_done", {63'd0, b_init_done}, 64'd0);
    chk("mid_rst_dbg", {32'd0, b_dbg_data}, 64'd0);
    chk("mid_rst_rd", b_rd_data, 64'd0);
    chk("mid_rst_sm_rd", sm_rd_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(1'b0, e_main, e_sm);
    chk("reinit_edges_32", 64'(e_main), 64'd32);
    @(negedge clk);
    chk("reinit_r9_r2", b_rd_data, {32'd4092, 32'd0});
    chk("reinit_sm_reads", sm_rd_data, {16'h0, 16'h0, 16'h0, 16'h0FF0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
